dcache_mem_req_scheduler: RTL and testbench
===========================================

# dcache_mem_req_scheduler

Schedules the D-cache miss handlers' (MSHRs') access to the single memory request port. Picks one requesting MSHR using round-robin priority and holds the grant, select and valid stable until memory accepts the request. Limits the number of outstanding line reads with a credit counter. Sits between the MSHR memory request/grant signals and the memory request multiplexer, and replaces the stateless memory request arbitration.

## Interface
Parameters:
- REQ_NUM, default MSHR_NUM (2): number of requesters; must be ≥2.
- MAX_OUTSTANDING, default 4: maximum in-flight reads; must be ≥1.
- CNT_WIDTH, default 32: width of the performance counters.

Ports (IDX_W = $clog2(REQ_NUM), OUT_W = $clog2(MAX_OUTSTANDING+1)):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- req  in  REQ_NUM  per-MSHR memory request.
- reqIsWrite  in  REQ_NUM  per-MSHR flag: 1 = write-back, 0 = line read; sampled with req.
- grant  out  REQ_NUM  one-hot grant; registered.
- memInSel  out  IDX_W  index of the granted MSHR; drives the request multiplexer select.
- memValid  out  1  request valid to memory.
- memReqAck  in  1  memory accepted the presented request this cycle.
- memReadDone  in  1  one read response delivered; frees a credit.
- outstanding  out  OUT_W  current in-flight read count.
- errUnderflow  out  1  sticky flag: memReadDone arrived while outstanding==0.
- perfGrantCount  out  CNT_WIDTH  only with DCACHE_MEM_SCHED_PERF_EN.
- perfCreditStall  out  CNT_WIDTH  only with DCACHE_MEM_SCHED_PERF_EN.

## Operation
- State: FSM {IDLE, ISSUE}; round-robin pointer `last` (IDX_W); `winner` register; `winnerIsWrite`; `outstanding` counter.
- Eligibility: req[i] && (reqIsWrite[i] || outstanding < MAX_OUTSTANDING). Writes need no credit.
- Pick: first eligible index scanning last+1, last+2, … (mod REQ_NUM).
- IDLE:
  - If any requester is eligible: register the pick into winner and grant, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Outputs: memValid=1, grant=onehot(winner), memInSel=winner. All stable until the state is left.
  - On memReqAck:
    - last←winner.
    - If the winner is a read, outstanding+1.
    - Re-pick in the same cycle. Use the updated last, exclude the winner, and use the post-increment credit count for eligibility. If a pick exists, stay in ISSUE with the new winner (back-to-back issue). Otherwise go to IDLE.
  - If req[winner] drops without memReqAck: cancel. Go to IDLE, no credit change, last unchanged.
- Credit update per cycle: outstanding += (read acked) − (memReadDone && outstanding>0).
  - A read acked and memReadDone in the same cycle leave the count unchanged.
  - The count never exceeds MAX_OUTSTANDING, because reads are ineligible at the limit.
- Underflow: memReadDone while outstanding==0 sets errUnderflow; the count stays 0. errUnderflow clears only on reset.
- Reset (rst=0, asynchronous):
  - State→IDLE, grant=0, memInSel=0, memValid=0.
  - outstanding=0, errUnderflow=0, last=REQ_NUM−1 (so index 0 has priority first), perf counters=0.
  - Reset mid-ISSUE drops the request immediately; in-flight credits are discarded.

## Timing
- req→memValid: one cycle (grant registered from IDLE).
- Back-to-back: with continuous memReqAck and eligible requesters, one request per cycle.
- After an ack, the next grant goes to a different requester whenever another is eligible.
- A credit freed by memReadDone at cycle t makes reads eligible in the pick at cycle t+1.
- All outputs are registered or decoded from registers only. No combinational path from memReqAck or req to memValid/grant within a cycle.

## Configuration
- DCACHE_MEM_SCHED_PERF_EN defined:
  - perfGrantCount increments on every memReqAck while memValid.
  - perfCreditStall increments on every cycle with a pending read req that is blocked only by outstanding==MAX_OUTSTANDING.
  - Both wrap modulo 2^CNT_WIDTH.
- Not defined: both ports are tied to 0 and no counter flops are present. Functional behaviour is otherwise identical.

## Test plan
- Reset/basic: rst low then high; req=01 read → cycle+1 memValid=1, grant=01, memInSel=0; hold memReqAck low 3 cycles → outputs stable; ack → outstanding=1.
- Round-robin: REQ_NUM=2, req=11 continuously, reads, ack every cycle, memReadDone every cycle → grants alternate 0,1,0,1 with memValid held high.
- Credit limit: MAX_OUTSTANDING=4, four reads acked with no memReadDone → outstanding=4; read req=01 gives memValid=0 and perfCreditStall counts up; pulse memReadDone → next cycle grant=01.
- Write bypass: outstanding=4, req0 read and req1 write → grant=10 issued; read stays blocked.
- Simultaneous/underflow: a read ack and memReadDone in the same cycle at outstanding=2 → stays 2; memReadDone at outstanding=0 → errUnderflow=1 and outstanding stays 0.
- Cancel and async reset: drop req[winner] in ISSUE → IDLE next cycle with no credit change; assert rst mid-ISSUE → memValid=0, grant=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dcache_mem_req_scheduler.sv
// Round-robin scheduler of MSHR requests onto the single memory request port, with a read-credit limit.
// Latency: req -> memValid one cycle; back-to-back issue on ack. Backpressure: grant/select/valid held until memReqAck.
// Optional DCACHE_MEM_SCHED_PERF_EN adds grant and credit-stall counters; otherwise those ports are tied to 0.
module dcache_mem_req_scheduler #(
    parameter int REQ_NUM         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32,
    localparam int IDX_W          = $clog2(REQ_NUM),
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_NUM-1:0]   req,
    input  logic [REQ_NUM-1:0]   reqIsWrite,
    output logic [REQ_NUM-1:0]   grant,
    output logic [IDX_W-1:0]     memInSel,
    output logic                 memValid,
    input  logic                 memReqAck,
    input  logic                 memReadDone,
    output logic [OUT_W-1:0]     outstanding,
    output logic                 errUnderflow,
    output logic [CNT_WIDTH-1:0] perfGrantCount,
    output logic [CNT_WIDTH-1:0] perfCreditStall
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [OUT_W:0] MAX_C = (OUT_W + 1)'(MAX_OUTSTANDING);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic                 win_wr_q, win_wr_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [REQ_NUM-1:0]   grant_q, grant_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 err_q, err_d;

    logic                 ack_fire, read_acked, done_dec;
    logic [OUT_W:0]       out_inc, out_nxt;
    logic [REQ_NUM-1:0]   elig_idle, elig_re;
    logic [IDX_W:0]       pick_idle, pick_re;

    // Returns {found, index}: first eligible index after 'start', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [REQ_NUM-1:0] elig,
                                                input logic [IDX_W-1:0]   start);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            int c;
            c = (int'(start) + i) % REQ_NUM;
            if (!found && elig[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        return {found, idx};
    endfunction

    assign ack_fire   = (state_q == ISSUE) && memReqAck;
    assign read_acked = ack_fire && !win_wr_q;
    assign done_dec   = memReadDone && (out_q != '0);
    assign out_inc    = {1'b0, out_q} + (OUT_W + 1)'(read_acked);
    assign out_nxt    = done_dec ? (out_inc - 1'b1) : out_inc;

    // Re-pick after an ack sees the credit already consumed by the acked read.
    always_comb begin
        elig_idle = '0;
        elig_re   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            elig_idle[i] = req[i] && (reqIsWrite[i] || ({1'b0, out_q} < MAX_C));
            elig_re[i]   = req[i] && (IDX_W'(i) != winner_q) &&
                           (reqIsWrite[i] || (out_inc < MAX_C));
        end
    end

    assign pick_idle = rr_pick(elig_idle, last_q);
    assign pick_re   = rr_pick(elig_re, winner_q);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        win_wr_d = win_wr_q;
        last_d   = last_q;
        grant_d  = grant_q;
        out_d    = out_nxt[OUT_W-1:0];
        err_d    = err_q | (memReadDone && (out_q == '0));
        case (state_q)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_d                         = ISSUE;
                    winner_d                        = pick_idle[IDX_W-1:0];
                    win_wr_d                        = reqIsWrite[pick_idle[IDX_W-1:0]];
                    grant_d                         = '0;
                    grant_d[pick_idle[IDX_W-1:0]]   = 1'b1;
                end
            end
            ISSUE: begin
                if (memReqAck) begin
                    last_d = winner_q;
                    if (pick_re[IDX_W]) begin
                        winner_d                    = pick_re[IDX_W-1:0];
                        win_wr_d                    = reqIsWrite[pick_re[IDX_W-1:0]];
                        grant_d                     = '0;
                        grant_d[pick_re[IDX_W-1:0]] = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (!req[winner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            win_wr_q <= 1'b0;
            last_q   <= IDX_W'(REQ_NUM - 1);
            grant_q  <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            win_wr_q <= win_wr_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign grant        = grant_q;
    assign memInSel     = winner_q;
    assign memValid     = (state_q == ISSUE);
    assign outstanding  = out_q;
    assign errUnderflow = err_q;

`ifdef DCACHE_MEM_SCHED_PERF_EN
    logic [CNT_WIDTH-1:0] perf_grant_q, perf_stall_q;
    logic                 stall_cond;

    // A read is stalled only by credits when the counter sits at the limit.
    assign stall_cond = (|(req & ~reqIsWrite)) && ({1'b0, out_q} == MAX_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (ack_fire)   perf_grant_q <= perf_grant_q + 1'b1;
            if (stall_cond) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perfGrantCount  = perf_grant_q;
    assign perfCreditStall = perf_stall_q;
`else
    assign perfGrantCount  = '0;
    assign perfCreditStall = '0;
`endif

endmodule

// File: tb/tb_dcache_mem_req_scheduler.sv
// Directed bench for dcache_mem_req_scheduler (REQ_NUM=2, MAX_OUTSTANDING=4).
// Expected issue indices are queued by the stimulus; a monitor pops them on each accepted request.
module tb_dcache_mem_req_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  reqIsWrite;
    logic [1:0]  grant;
    logic [0:0]  memInSel;
    logic        memValid;
    logic        memReqAck;
    logic        memReadDone;
    logic [2:0]  outstanding;
    logic        errUnderflow;
    logic [31:0] perfGrantCount;
    logic [31:0] perfCreditStall;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dcache_mem_req_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .reqIsWrite      (reqIsWrite),
        .grant           (grant),
        .memInSel        (memInSel),
        .memValid        (memValid),
        .memReqAck       (memReqAck),
        .memReadDone     (memReadDone),
        .outstanding     (outstanding),
        .errUnderflow    (errUnderflow),
        .perfGrantCount  (perfGrantCount),
        .perfCreditStall (perfCreditStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted request must match the next queued expectation.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst && memValid && memReqAck) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: sel %0d grant %b with nothing expected", memInSel, grant);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_sel", 32'(memInSel), e);
                    chk("issue_grant", 32'(grant), 32'(1) << e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; req = '0; reqIsWrite = '0; memReqAck = 1'b0; memReadDone = 1'b0;
        #12;
        chk("rst_valid", 32'(memValid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel", 32'(memInSel), 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_err", 32'(errUnderflow), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Basic: single read, held for three cycles, then acked.
        req = 2'b01; exp_q.push_back(0);
        step();
        chk("basic_valid", 32'(memValid), 1);
        chk("basic_grant", 32'(grant), 32'b01);
        chk("basic_sel", 32'(memInSel), 0);
        repeat (3) begin
            step();
            chk("hold_valid", 32'(memValid), 1);
            chk("hold_grant", 32'(grant), 32'b01);
        end
        memReqAck = 1'b1;
        step();
        memReqAck = 1'b0; req = '0;
        chk("basic_out", 32'(outstanding), 1);
        chk("basic_idle", 32'(memValid), 0);
        memReadDone = 1'b1;
        step();
        memReadDone = 1'b0;
        chk("basic_drain", 32'(outstanding), 0);

        // Round-robin: last winner was 0, so requester 1 goes first.
        req = 2'b11; memReqAck = 1'b1;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        step();
        step();
        chk("rr_valid", 32'(memValid), 1);
        memReadDone = 1'b1;
        repeat (3) begin
            step();
            chk("rr_valid", 32'(memValid), 1);
        end
        memReqAck = 1'b0; req = '0; memReadDone = 1'b0;
        step();
        chk("rr_cancel_idle", 32'(memValid), 0);
        chk("rr_out", 32'(outstanding), 1);
        memReadDone = 1'b1;
        step();
        memReadDone = 1'b0;
        chk("rr_drain", 32'(outstanding), 0);

        // Credit limit: four reads from requester 0 fill the credits.
        req = 2'b01; memReqAck = 1'b1;
        repeat (4) exp_q.push_back(0);
        repeat (8) step();
        memReqAck = 1'b0;
        chk("limit_out", 32'(outstanding), 4);
        chk("limit_valid", 32'(memValid), 0);
        repeat (3) begin
            step();
            chk("limit_blocked", 32'(memValid), 0);
            chk("limit_out_hold", 32'(outstanding), 4);
        end
`ifdef DCACHE_MEM_SCHED_PERF_EN
        chk("limit_stall_cnt", perfCreditStall, 3);
`else
        chk("limit_stall_cnt", perfCreditStall, 0);
`endif
        memReadDone = 1'b1;
        step();
        memReadDone = 1'b0;
        chk("credit_freed", 32'(outstanding), 3);
        chk("credit_not_yet", 32'(memValid), 0);
        exp_q.push_back(0);
        step();
        chk("credit_grant_valid", 32'(memValid), 1);
        chk("credit_grant", 32'(grant), 32'b01);
        memReqAck = 1'b1;
        step();
        memReqAck = 1'b0; req = 2'b11; reqIsWrite = 2'b10;
        chk("limit_again", 32'(outstanding), 4);

        // Write bypass at the credit limit.
        exp_q.push_back(1);
        step();
        chk("wr_valid", 32'(memValid), 1);
        chk("wr_grant", 32'(grant), 32'b10);
        chk("wr_sel", 32'(memInSel), 1);
        memReqAck = 1'b1;
        step();
        memReqAck = 1'b0; req = 2'b01; reqIsWrite = 2'b00;
        chk("wr_no_credit", 32'(outstanding), 4);
        step();
        chk("wr_read_blocked", 32'(memValid), 0);
        req = '0;

        // Simultaneous ack and read completion at outstanding=2.
        memReadDone = 1'b1;
        step();
        step();
        memReadDone = 1'b0;
        chk("sim_pre", 32'(outstanding), 2);
        req = 2'b01; exp_q.push_back(0);
        step();
        chk("sim_valid", 32'(memValid), 1);
        memReqAck = 1'b1; memReadDone = 1'b1;
        step();
        memReqAck = 1'b0; memReadDone = 1'b0; req = '0;
        chk("sim_out", 32'(outstanding), 2);

        // Underflow.
        memReadDone = 1'b1;
        step();
        step();
        memReadDone = 1'b0;
        chk("uf_pre_out", 32'(outstanding), 0);
        chk("uf_pre_err", 32'(errUnderflow), 0);
        memReadDone = 1'b1;
        step();
        memReadDone = 1'b0;
        chk("uf_err", 32'(errUnderflow), 1);
        chk("uf_out", 32'(outstanding), 0);
        step();
        chk("uf_sticky", 32'(errUnderflow), 1);

        // Cancel: last winner was 0, so requester 1 is picked.
        req = 2'b10;
        step();
        chk("cancel_valid", 32'(memValid), 1);
        chk("cancel_grant", 32'(grant), 32'b10);
        req = '0;
        step();
        chk("cancel_idle", 32'(memValid), 0);
        chk("cancel_grant0", 32'(grant), 0);
        chk("cancel_out", 32'(outstanding), 0);
        req = 2'b11;
        step();
        chk("cancel_last_kept", 32'(memInSel), 1);
        chk("cancel_regrant", 32'(grant), 32'b10);
`ifdef DCACHE_MEM_SCHED_PERF_EN
        chk("perf_grants", perfGrantCount, 12);
        chk("perf_stalls", perfCreditStall, 7);
`else
        chk("perf_grants", perfGrantCount, 0);
        chk("perf_stalls", perfCreditStall, 0);
`endif

        // Asynchronous reset mid-ISSUE, well away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(memValid), 0);
        chk("arst_grant", 32'(grant), 0);
        chk("arst_sel", 32'(memInSel), 0);
        chk("arst_err", 32'(errUnderflow), 0);
        chk("arst_perf", perfGrantCount, 0);
        @(negedge clk);
        rst = 1'b1; req = '0;
        step();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
